// File: rtl/aes_pkg.sv
// Shared AES-128 constants: round count, round constants and key-expansion FSM encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_EXPAND = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // Indexed directly by the round counter; entries 0 and 11..15 are never used in a live round.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys, one round per cycle,
// and serves any stored round key on a registered read port.
module aes_key_expand #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [127:0] key_in,
  input  logic         key_valid_in,
  output logic         key_ready_out,
  input  logic [3:0]   round_idx_in,
  output logic [127:0] round_key_out,
  output logic         keys_valid_out,
  output logic [1:0]   dbg_state_out
);

  import aes_pkg::*;

  // Handshake: a key is taken on any rising edge where key_valid_in && key_ready_out.
  // key_ready_out depends only on state, so it never combinationally follows key_valid_in.
  state_t        state;
  logic [3:0]    ctr;
  logic [127:0]  rk [0:10];
  logic [127:0]  rk_prev;
  logic [127:0]  rk_next;
  logic [127:0]  rk_sel;
  logic [31:0]   rot;
  logic [31:0]   sub;
  logic [31:0]   temp;
  logic [31:0]   w0n, w1n, w2n, w3n;
  logic          accept;

  assign key_ready_out = (state != ST_EXPAND);
  assign accept        = key_valid_in && key_ready_out;
  assign dbg_state_out = state;

  always_comb begin
    rk_prev = '0;
    for (int i = 1; i <= 10; i++) begin
      if (ctr == 4'(i)) rk_prev = rk[i-1];
    end
  end

  assign rot = rot_word(rk_prev[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot[8*g +: 8]),
      .out_byte (sub[8*g +: 8])
    );
  end

  assign temp    = sub ^ {RCON[ctr], 24'h000000};
  assign w0n     = rk_prev[127:96] ^ temp;
  assign w1n     = rk_prev[95:64]  ^ w0n;
  assign w2n     = rk_prev[63:32]  ^ w1n;
  assign w3n     = rk_prev[31:0]   ^ w2n;
  assign rk_next = {w0n, w1n, w2n, w3n};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      ctr            <= 4'd0;
      keys_valid_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (key_valid_in) begin
            ctr            <= 4'd1;
            keys_valid_out <= 1'b0;
            state          <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (ctr == 4'(NR)) begin
            state          <= ST_DONE;
            keys_valid_out <= 1'b1;
          end else begin
            ctr <= ctr + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Round-key storage is deliberately unreset; keys_valid_out guards its contents.
  always_ff @(posedge clk_in) begin
    if (accept) rk[0] <= key_in;
    if (state == ST_EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (ctr == 4'(i)) rk[i] <= rk_next;
      end
    end
  end

  always_comb begin
    rk_sel = '0;
    for (int i = 0; i <= 10; i++) begin
      if (round_idx_in == 4'(i)) rk_sel = rk[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) round_key_out <= '0;
    else           round_key_out <= rk_sel;
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: known-answer vectors, reload, restart-ignore and reset-abort.
module tb_aes_key_expand;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [127:0] key_in;
  logic         key_valid_in;
  logic         key_ready_out;
  logic [3:0]   round_idx_in;
  logic [127:0] round_key_out;
  logic         keys_valid_out;
  logic [1:0]   dbg_state_out;

  int checks = 0;
  int passed = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk_in = ~clk_in;

  aes_key_expand #(.NR(10)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .key_in         (key_in),
    .key_valid_in   (key_valid_in),
    .key_ready_out  (key_ready_out),
    .round_idx_in   (round_idx_in),
    .round_key_out  (round_key_out),
    .keys_valid_out (keys_valid_out),
    .dbg_state_out  (dbg_state_out)
  );

  // Reference model: S-box derived from GF(2^8) inverse plus affine map, Rcon by repeated doubling.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    if (a != 8'h00) begin
      for (int b = 1; b < 256; b++) begin
        if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      end
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc = 8'h01;
    {w0, w1, w2, w3} = key;
    for (int i = 1; i <= r; i++) begin
      t = {model_sbox(w3[23:16]), model_sbox(w3[15:8]), model_sbox(w3[7:0]), model_sbox(w3[31:24])};
      t[31:24] = t[31:24] ^ rc;
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rc = gmul(rc, 8'h02);
    end
    return {w0, w1, w2, w3};
  endfunction

  task automatic accept_key(input logic [127:0] k);
    key_in       = k;
    key_valid_in = 1'b1;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
  endtask

  // Returns the number of edges until keys_valid_out rises, or -1 if it never does within 20.
  task automatic wait_keys_valid(output int n);
    n = -1;
    for (int i = 1; i <= 20 && n < 0; i++) begin
      @(posedge clk_in); #1;
      if (keys_valid_out) n = i;
    end
  endtask

  task automatic read_key(input logic [3:0] idx, output logic [127:0] v);
    round_idx_in = idx;
    @(posedge clk_in); #1;
    v = round_key_out;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (keys_valid_out !== 1'b0) $display("FAIL reset_keys_valid: got %b expected 0", keys_valid_out); else passed++;
    checks++; if (key_ready_out !== 1'b1) $display("FAIL reset_key_ready: got %b expected 1", key_ready_out); else passed++;
    checks++; if (round_key_out !== '0) $display("FAIL reset_round_key: got %h expected 0", round_key_out); else passed++;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
  endtask

  // Reads 10 down to 0 then 11, one index per cycle, checking each against the queued expectation.
  task automatic test_sweep(input logic [127:0] key);
    logic [127:0] got, exp;
    int idx;
    for (int k = 0; k < 12; k++) begin
      idx = (k < 11) ? 10 - k : 11;
      round_idx_in = 4'(idx);
      exp_q.push_back((idx <= 10) ? model_rk(key, idx) : 128'h0);
      @(posedge clk_in); #1;
      got = round_key_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL sweep_idx%0d: got %h expected %h", idx, got, exp); else passed++;
    end
  endtask

  task automatic test_random_reads(input logic [127:0] key);
    logic [127:0] got, exp;
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = $urandom_range(0, 15);
      round_idx_in = 4'(idx);
      exp_q.push_back((idx <= 10) ? model_rk(key, idx) : 128'h0);
      @(posedge clk_in); #1;
      got = round_key_out;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) $display("FAIL random_read_idx%0d: got %h expected %h", idx, got, exp); else passed++;
    end
  endtask

  task automatic test_fips;
    int n;
    logic [127:0] v;
    accept_key(FIPS_KEY);
    checks++; if (keys_valid_out !== 1'b0) $display("FAIL fips_kv_after_accept: got %b expected 0", keys_valid_out); else passed++;
    checks++; if (key_ready_out !== 1'b0) $display("FAIL fips_ready_in_expand: got %b expected 0", key_ready_out); else passed++;
    wait_keys_valid(n);
    checks++; if (n != 10) $display("FAIL fips_latency: got %0d expected 10", n); else passed++;
    checks++; if (key_ready_out !== 1'b1) $display("FAIL fips_ready_in_done: got %b expected 1", key_ready_out); else passed++;
    read_key(4'd1, v);
    checks++; if (v !== FIPS_RK1) $display("FAIL fips_rk1: got %h expected %h", v, FIPS_RK1); else passed++;
    read_key(4'd10, v);
    checks++; if (v !== FIPS_RK10) $display("FAIL fips_rk10: got %h expected %h", v, FIPS_RK10); else passed++;
    test_sweep(FIPS_KEY);
    test_random_reads(FIPS_KEY);
  endtask

  task automatic test_zero_key;
    int n;
    logic [127:0] v;
    accept_key(128'h0);
    wait_keys_valid(n);
    checks++; if (n != 10) $display("FAIL zero_latency: got %0d expected 10", n); else passed++;
    read_key(4'd1, v);
    checks++; if (v !== ZERO_RK1) $display("FAIL zero_rk1: got %h expected %h", v, ZERO_RK1); else passed++;
    read_key(4'd10, v);
    checks++; if (v !== ZERO_RK10) $display("FAIL zero_rk10: got %h expected %h", v, ZERO_RK10); else passed++;
  endtask

  task automatic test_ignore_restart;
    int n;
    logic [127:0] key_a, key_b, v;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = ~key_a;
    accept_key(key_a);
    repeat (3) @(posedge clk_in);
    #1;
    key_in       = key_b;
    key_valid_in = 1'b1;
    checks++; if (key_ready_out !== 1'b0) $display("FAIL ignore_ready: got %b expected 0", key_ready_out); else passed++;
    @(posedge clk_in); #1;
    key_valid_in = 1'b0;
    wait_keys_valid(n);
    checks++; if (n != 6) $display("FAIL ignore_latency: got %0d expected 6", n); else passed++;
    read_key(4'd10, v);
    checks++; if (v !== model_rk(key_a, 10)) $display("FAIL ignore_rk10: got %h expected %h", v, model_rk(key_a, 10)); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    logic [127:0] key_a;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    accept_key(key_a);
    repeat (4) @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++; if (keys_valid_out !== 1'b0) $display("FAIL midrst_keys_valid: got %b expected 0", keys_valid_out); else passed++;
    checks++; if (key_ready_out !== 1'b1) $display("FAIL midrst_key_ready: got %b expected 1", key_ready_out); else passed++;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (12) @(posedge clk_in);
    #1;
    checks++; if (keys_valid_out !== 1'b0) $display("FAIL midrst_stays_invalid: got %b expected 0", keys_valid_out); else passed++;
    accept_key(key_a);
    wait_keys_valid(n);
    checks++; if (n != 10) $display("FAIL midrst_reaccept_latency: got %0d expected 10", n); else passed++;
    test_sweep(key_a);
  endtask

  task automatic test_back_to_back;
    int n;
    logic [127:0] key_c, v;
    key_c = {$urandom, $urandom, $urandom, $urandom};
    checks++; if (keys_valid_out !== 1'b1) $display("FAIL b2b_done_before: got %b expected 1", keys_valid_out); else passed++;
    accept_key(key_c);
    checks++; if (keys_valid_out !== 1'b0) $display("FAIL b2b_kv_at_t0: got %b expected 0", keys_valid_out); else passed++;
    wait_keys_valid(n);
    checks++; if (n != 10) $display("FAIL b2b_latency: got %0d expected 10", n); else passed++;
    read_key(4'd10, v);
    checks++; if (v !== model_rk(key_c, 10)) $display("FAIL b2b_rk10: got %h expected %h", v, model_rk(key_c, 10)); else passed++;
    read_key(4'd0, v);
    checks++; if (v !== key_c) $display("FAIL b2b_rk0: got %h expected %h", v, key_c); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in     = 1'b0;
    key_in       = '0;
    key_valid_in = 1'b0;
    round_idx_in = 4'd0;
    test_reset();
    test_fips();
    test_zero_key();
    test_ignore_restart();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
